// File: rtl/c_dly_fine_ctrl.sv
// Fine delay-line controller: filters phase-detector up/down requests into a
// 0..64 code, drives a 64-stage thermometer select and reports lock/saturation.
// Optional build macro: C_DLY_FINE_CTRL_FREEZE_EN (freeze accumulator and code while locked).
module c_dly_fine_ctrl #(
    parameter int unsigned FILT_TH = 8,
    parameter int unsigned LOCK_N  = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic        i_up,
    input  logic        i_dn,
    input  logic        i_load,
    input  logic [6:0]  i_load_code,
    output logic [63:0] o_sel,
    output logic [6:0]  o_code,
    output logic        o_lock,
    output logic        o_sat
);

    typedef enum logic [1:0] {StIdle, StTrack, StLock} state_e;

    localparam logic signed [8:0] TH_POS   = 9'(FILT_TH);
    localparam logic signed [8:0] TH_NEG   = -TH_POS;
    localparam logic [3:0]        LOCK_CNT = 4'(LOCK_N);
    localparam logic [6:0]        CODE_MAX = 7'd64;

    state_e             state_q, state_d;
    logic [6:0]         code_q, code_d;
    logic [63:0]        sel_q, sel_d;
    logic signed [7:0]  acc_q, acc_d;
    logic [3:0]         alt_q, alt_d;
    logic               dir_vld_q, dir_vld_d;
    logic               dir_up_q, dir_up_d;
    logic               sat_q, sat_d;

    logic signed [8:0]  acc_ext, acc_sum;
    logic               track_act, step_up, step_dn, step_sat, step_real, step_alt;

    // Filter arithmetic and step classification
    always_comb begin
        acc_ext = {acc_q[7], acc_q};
        acc_sum = acc_ext;
        if (i_up && !i_dn) begin
            acc_sum = acc_ext + 9'sd1;
        end else if (i_dn && !i_up) begin
            acc_sum = acc_ext - 9'sd1;
        end
`ifdef C_DLY_FINE_CTRL_FREEZE_EN
        track_act = (state_q == StTrack);
`else
        track_act = (state_q == StTrack) || (state_q == StLock);
`endif
        step_up   = (acc_sum == TH_POS);
        step_dn   = (acc_sum == TH_NEG);
        step_sat  = (step_up && (code_q == CODE_MAX)) || (step_dn && (code_q == 7'd0));
        step_real = (step_up || step_dn) && !step_sat;
        // First step after a clear counts as the start of an alternating run
        step_alt  = !dir_vld_q || (dir_up_q != step_up);
    end

    // Next-state: load beats disable beats filter steps
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        acc_d     = acc_q;
        alt_d     = alt_q;
        dir_vld_d = dir_vld_q;
        dir_up_d  = dir_up_q;
        sat_d     = sat_q;
        if (i_load) begin
            code_d    = (i_load_code > CODE_MAX) ? CODE_MAX : i_load_code;
            acc_d     = '0;
            alt_d     = '0;
            dir_vld_d = 1'b0;
            sat_d     = 1'b0;
            state_d   = i_en ? StTrack : StIdle;
        end else if (!i_en) begin
            state_d   = StIdle;
            acc_d     = '0;
            alt_d     = '0;
            dir_vld_d = 1'b0;
            sat_d     = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StTrack;
                end
                StTrack, StLock: begin
                    if (track_act) begin
                        if (step_sat) begin
                            acc_d     = '0;
                            sat_d     = 1'b1;
                            alt_d     = '0;
                            dir_vld_d = 1'b0;
                        end else if (step_real) begin
                            acc_d     = '0;
                            sat_d     = 1'b0;
                            code_d    = step_up ? code_q + 7'd1 : code_q - 7'd1;
                            dir_vld_d = 1'b1;
                            dir_up_d  = step_up;
                            if (step_alt) begin
                                alt_d = (alt_q >= LOCK_CNT) ? alt_q : alt_q + 4'd1;
                                if ((state_q == StTrack) && (alt_q + 4'd1 >= LOCK_CNT)) begin
                                    state_d = StLock;
                                end
                            end else begin
                                // A repeated direction starts a fresh run of length one
                                alt_d = 4'd1;
                                if (state_q == StLock) begin
                                    state_d = StTrack;
                                end
                            end
                        end else begin
                            acc_d = acc_sum[7:0];
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Thermometer select tracks the next code so both register on the same edge
    always_comb begin
        sel_d = '0;
        for (int k = 0; k < 64; k++) begin
            sel_d[k] = (7'(k) < code_d);
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= StIdle;
            code_q    <= '0;
            sel_q     <= '0;
            acc_q     <= '0;
            alt_q     <= '0;
            dir_vld_q <= 1'b0;
            dir_up_q  <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            sel_q     <= sel_d;
            acc_q     <= acc_d;
            alt_q     <= alt_d;
            dir_vld_q <= dir_vld_d;
            dir_up_q  <= dir_up_d;
            sat_q     <= sat_d;
        end
    end

    assign o_sel  = sel_q;
    assign o_code = code_q;
    assign o_lock = (state_q == StLock);
    assign o_sat  = sat_q;

endmodule

// File: tb/tb_c_dly_fine_ctrl.sv
// Self-checking bench for c_dly_fine_ctrl: directed vector table, hand-written
// reset sequences, then randomized traffic against a behavioural model.
module tb_c_dly_fine_ctrl;

    localparam int FILT_TH = 8;
    localparam int LOCK_N  = 4;
`ifdef C_DLY_FINE_CTRL_FREEZE_EN
    localparam int FREEZE = 1;
`else
    localparam int FREEZE = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0, up = 1'b0, dn = 1'b0, ld = 1'b0;
    logic [6:0]  lc = '0;
    logic [63:0] sel;
    logic [6:0]  code;
    logic        lock, sat;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    c_dly_fine_ctrl #(.FILT_TH(FILT_TH), .LOCK_N(LOCK_N)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_en        (en),
        .i_up        (up),
        .i_dn        (dn),
        .i_load      (ld),
        .i_load_code (lc),
        .o_sel       (sel),
        .o_code      (code),
        .o_lock      (lock),
        .o_sat       (sat)
    );

    function automatic logic [63:0] therm(int c);
        if (c >= 64) return '1;
        return (64'd1 << c) - 64'd1;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, int ec, int el, int es);
        chk({tag, " code"}, 64'(code), 64'(ec));
        chk({tag, " sel"},  sel,       therm(ec));
        chk({tag, " lock"}, 64'(lock), 64'(el));
        chk({tag, " sat"},  64'(sat),  64'(es));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed vector table
    typedef struct {
        string tag;
        bit    en, up, dn, ld;
        int    lc;
        int    code, lock, sat;
    } vec_t;

    vec_t vecs[$];
    int   p_code = 0, p_lock = 0, p_sat = 0;

    // Append reps identical input rows; outputs hold until the last row, which expects x*
    task automatic push(string tag, int e, int u, int d, int l, int c, int reps,
                        int xc, int xl, int xs);
        for (int i = 0; i < reps; i++) begin
            vec_t v;
            v.tag = tag;
            v.en = (e != 0); v.up = (u != 0); v.dn = (d != 0); v.ld = (l != 0);
            v.lc = c;
            if (i == reps - 1) begin
                v.code = xc; v.lock = xl; v.sat = xs;
            end else begin
                v.code = p_code; v.lock = p_lock; v.sat = p_sat;
            end
            vecs.push_back(v);
        end
        p_code = xc; p_lock = xl; p_sat = xs;
    endtask

    // Behavioural reference: step history instead of counters
    int m_mode;  // 0 idle, 1 track, 2 lock
    int m_code, m_acc;
    int m_sat;
    int m_hist[$];

    task automatic model_reset();
        m_mode = 0; m_code = 0; m_acc = 0; m_sat = 0;
        m_hist.delete();
    endtask

    function automatic int run_len();
        int n;
        if (m_hist.size() == 0) return 0;
        n = 1;
        for (int i = m_hist.size() - 1; i > 0; i--) begin
            if (m_hist[i] != m_hist[i-1]) n++;
            else break;
        end
        return n;
    endfunction

    task automatic model_step(bit e, bit u, bit d, bit l, int c);
        int dlt, a, dir, nc, sz;
        if (l) begin
            m_code = (c > 64) ? 64 : c;
            m_acc = 0; m_sat = 0; m_hist.delete();
            m_mode = e ? 1 : 0;
            return;
        end
        if (!e) begin
            m_mode = 0; m_acc = 0; m_sat = 0; m_hist.delete();
            return;
        end
        if (m_mode == 0) begin
            m_mode = 1;
            return;
        end
        if (FREEZE != 0 && m_mode == 2) return;
        dlt = (u && !d) ? 1 : (d && !u) ? -1 : 0;
        a = m_acc + dlt;
        if (a == FILT_TH || a == -FILT_TH) begin
            m_acc = 0;
            dir = (a > 0) ? 1 : -1;
            nc = m_code + dir;
            if (nc < 0 || nc > 64) begin
                m_sat = 1;
                m_hist.delete();
            end else begin
                m_code = nc;
                m_sat = 0;
                m_hist.push_back(dir);
                if (m_hist.size() > 32) void'(m_hist.pop_front());
                sz = m_hist.size();
                if (m_mode == 1 && run_len() >= LOCK_N) m_mode = 2;
                else if (m_mode == 2 && sz >= 2 && m_hist[sz-1] == m_hist[sz-2]) m_mode = 1;
            end
        end else begin
            m_acc = a;
        end
    endtask

    initial begin
        int bias, seg_left, r;

        push("en",       1, 0, 0, 0,   0,  1,  0, 0, 0);
        push("up8",      1, 1, 0, 0,   0,  8,  1, 0, 0);
        push("dn8",      1, 0, 1, 0,   0,  8,  0, 0, 0);
        push("up8b",     1, 1, 0, 0,   0,  8,  1, 0, 0);
        push("dn8_lock", 1, 0, 1, 0,   0,  8,  0, 1, 0);
        push("up8_alt",  1, 1, 0, 0,   0,  8,  (FREEZE != 0) ? 0 : 1, 1, 0);
        push("up8_same", 1, 1, 0, 0,   0,  8,  (FREEZE != 0) ? 0 : 2, (FREEZE != 0) ? 1 : 0, 0);
        push("load100",  1, 0, 0, 1, 100,  1, 64, 0, 0);
        push("up8_sat",  1, 1, 0, 0,   0,  8, 64, 0, 1);
        push("dn3",      1, 0, 1, 0,   0,  3, 64, 0, 1);
        push("both50",   1, 1, 1, 0,   0, 50, 64, 0, 1);
        push("dn5",      1, 0, 1, 0,   0,  5, 63, 0, 0);
        push("en0",      0, 0, 0, 0,   0,  1, 63, 0, 0);
        push("ld_idle",  0, 0, 0, 1,  10,  1, 10, 0, 0);
        push("idle_up",  0, 1, 0, 0,   0,  8, 10, 0, 0);
        push("en1",      1, 0, 0, 0,   0,  1, 10, 0, 0);
        push("up7",      1, 1, 0, 0,   0,  7, 10, 0, 0);
        push("ld_prio",  1, 1, 0, 1,   5,  1,  5, 0, 0);
        push("up7b",     1, 1, 0, 0,   0,  7,  5, 0, 0);
        push("up1",      1, 1, 0, 0,   0,  1,  6, 0, 0);
        push("ld0",      1, 0, 0, 1,   0,  1,  0, 0, 0);
        push("dn8_sat0", 1, 0, 1, 0,   0,  8,  0, 0, 1);
        push("en0_sat",  0, 0, 0, 0,   0,  1,  0, 0, 0);
        push("en1b",     1, 0, 0, 0,   0,  1,  0, 0, 0);
        push("ld20",     1, 0, 0, 1,  20,  1, 20, 0, 0);
        push("up3",      1, 1, 0, 0,   0,  3, 20, 0, 0);

        // Reset state without any clock edge
        #2;
        check_all("reset", 0, 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;

        foreach (vecs[i]) begin
            en = vecs[i].en; up = vecs[i].up; dn = vecs[i].dn; ld = vecs[i].ld;
            lc = 7'(vecs[i].lc);
            tick();
            check_all(vecs[i].tag, vecs[i].code, vecs[i].lock, vecs[i].sat);
        end
        en = 1'b1; up = 1'b0; dn = 1'b0; ld = 1'b0;

        // Asynchronous reset in TRACK at code 20, between clock edges
        #3 rstn = 1'b0;
        #1 check_all("async_rst", 0, 0, 0);
        #2 rstn = 1'b1;

        // Resume from IDLE: the three leftover up counts must be gone
        tick();
        check_all("resume_idle", 0, 0, 0);
        up = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_all("resume_hold", 0, 0, 0);
        end
        tick();
        check_all("resume_step", 1, 0, 0);

        // Reach lock again, then reset asynchronously while locked
        for (int s = 0; s < 3; s++) begin
            up = (s % 2 == 1); dn = (s % 2 == 0);
            for (int i = 0; i < FILT_TH; i++) tick();
        end
        check_all("relock", 0, 1, 0);
        up = 1'b0; dn = 1'b0;
        #3 rstn = 1'b0;
        #1 check_all("async_rst_lock", 0, 0, 0);
        #2 rstn = 1'b1;
        model_reset();

        // Randomized traffic against the reference model
        bias = 0; seg_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (seg_left == 0) begin
                bias = $urandom_range(0, 2);
                seg_left = $urandom_range(10, 24);
            end
            seg_left--;
            en = ($urandom_range(0, 99) != 0);
            ld = ($urandom_range(0, 99) < 2);
            lc = 7'($urandom_range(0, 127));
            r = $urandom_range(0, 3);
            case (bias)
                0: begin up = (r != 0); dn = (r == 3); end
                1: begin dn = (r != 0); up = (r == 3); end
                default: begin up = r[0]; dn = r[1]; end
            endcase
            tick();
            model_step(en, up, dn, ld, int'(lc));
            check_all("rand", m_code, (m_mode == 2) ? 1 : 0, m_sat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/c_dly_fine_ctrl.md
C_DLY_FINE_CTRL -- requirements
Module: c_dly_fine_ctrl

Interface
REQ-001 SHALL have parameter FILT_TH, default 8, meaning net i_up/i_dn count needed to move the code by one step (2..127).
REQ-002 SHALL have parameter LOCK_N, default 4, meaning consecutive direction-alternating steps needed to declare lock (2..15).
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port i_en, input, 1, tracking enable.
REQ-006 SHALL have port i_up, input, 1, phase-detector request for more delay (sampled each cycle).
REQ-007 SHALL have port i_dn, input, 1, phase-detector request for less delay (sampled each cycle).
REQ-008 SHALL have port i_load, input, 1, one-cycle forced code load strobe.
REQ-009 SHALL have port i_load_code, input, 7, code to load.
REQ-010 SHALL have port o_sel, output, 64, thermometer select driving a 64-stage fine delay chain.
REQ-011 SHALL have port o_code, output, 7, current binary code 0..64.
REQ-012 SHALL have port o_lock, output, 1, loop locked.
REQ-013 SHALL have port o_sat, output, 1, code is 0 or 64 and the filter demanded a step beyond it.

Function
REQ-014 SHALL keep o_sel[k]=1 exactly for k<o_code at every cycle; o_sel and o_code registered, updated in the same cycle.
REQ-015 SHALL implement states IDLE, TRACK, LOCK; IDLE->TRACK when i_en=1; TRACK->LOCK after LOCK_N consecutive alternating steps; LOCK->TRACK on two consecutive same-direction steps; any state->IDLE when i_en=0 (next cycle).
REQ-016 SHALL, in IDLE, hold o_code, clear the filter accumulator and alternation counter.
REQ-017 SHALL, in TRACK/LOCK, add +1 to a signed accumulator for i_up&!i_dn, -1 for i_dn&!i_up, 0 when both or neither.
REQ-018 SHALL, when the accumulator would reach +FILT_TH, increment o_code (if <64) on that edge and clear the accumulator; symmetrically -FILT_TH decrements (if >0).
REQ-019 SHALL, at code 64 with an up step or code 0 with a down step, leave o_code unchanged, clear the accumulator, set o_sat; o_sat clears on the next real step, load or IDLE.
REQ-020 SHALL count a step as alternating when its direction differs from the previous step; a saturated step resets the alternation counter to 0.
REQ-021 SHALL, on i_load=1, set o_code to min(i_load_code,64) next cycle, clear accumulator, alternation counter, o_sat, enter TRACK if i_en=1 else IDLE; i_load has priority over any filter step in the same cycle.
REQ-022 SHALL assert o_lock exactly while in state LOCK, registered.

Reset
REQ-023 SHALL, on i_rstn=0, asynchronously force state IDLE, o_code=0, o_sel=0, o_lock=0, o_sat=0, accumulator and alternation counter 0.
REQ-024 SHALL, after i_rstn deassertion mid-operation, resume from IDLE with no residual filter state.

Configuration
REQ-025 SHALL support macro C_DLY_FINE_CTRL_FREEZE_EN: defined -> in LOCK the accumulator is frozen and o_code held, leaving LOCK only via i_en=0, i_load or reset; undefined -> tracking continues in LOCK per REQ-017..REQ-020.

Verification
REQ-026 SHALL verify: reset, i_en=1, i_up=1 for 8 cycles (FILT_TH=8) -> o_code=1, o_sel=64'h1 one edge after 8th sample.
REQ-027 SHALL verify: i_load=1, i_load_code=100 -> o_code=64, o_sel=all ones; then 8 i_up -> o_code=64, o_sat=1.
REQ-028 SHALL verify: i_up and i_dn both high 50 cycles -> o_code unchanged, accumulator unchanged.
REQ-029 SHALL verify: steps +,-,+,- (LOCK_N=4) -> o_lock=1 after 4th step; then two + steps -> o_lock=0 (macro undefined); with macro defined o_code stays fixed in LOCK.
REQ-030 SHALL verify: i_rstn low during TRACK at o_code=20 -> o_code=0, o_sel=0, o_lock=0 immediately, without a clock edge.
